// File: rtl/minc_pkg.sv
// Shared types and constants for the minc boot/run controller.
package minc_pkg;

  localparam int IMEM_AW = 8;
  localparam int INSTR_W = 15;

  localparam logic [7:0] CMD_LOAD = 8'hA5;
  localparam logic [7:0] CMD_RUN  = 8'h5A;
  localparam logic [7:0] CMD_HALT = 8'hC3;

  typedef enum logic [2:0] {
    ST_HALT,
    ST_RUN,
    ST_LEN,
    ST_LO,
    ST_HI,
    ST_WRITE,
    ST_CSUM
  } boot_state_t;

endpackage

// File: rtl/minc_boot_ctrl_if.sv
// Byte-stream input and instruction-memory write port of the boot controller.
interface minc_boot_if;
  import minc_pkg::*;

  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [INSTR_W-1:0] imem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/minc_boot_ctrl.sv
// Boot/run controller: loads checksummed program frames into instruction memory
// and gates the core reset.
//
// state    | meaning
// ST_HALT  | core held in reset, waiting for LOAD or RUN
// ST_RUN   | core released, waiting for HALT or LOAD
// ST_LEN   | expecting word count N (0 means 256)
// ST_LO    | expecting low byte of the current word
// ST_HI    | expecting high byte of the current word
// ST_WRITE | single-cycle memory write, byte input stalled
// ST_CSUM  | expecting checksum byte
module minc_boot_ctrl
  import minc_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic             CLK,
  input  logic             nRESET,
  minc_boot_if.slave       bus,
  output logic             core_nreset,
  output logic             err,
  output logic [8:0]       loaded_words
);

  localparam int TW = $clog2(TIMEOUT + 1);

  boot_state_t        state_q, state_d;
  logic [8:0]         n_q, n_d;
  logic [8:0]         idx_q, idx_d;
  logic [7:0]         csum_q, csum_d;
  logic [7:0]         lo_q, lo_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic               rx_ready_q, rx_ready_d;
  logic               we_q, we_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic [INSTR_W-1:0] wdata_q, wdata_d;
  logic               core_q, core_d;
  logic               err_q, err_d;
  logic [8:0]         loaded_q, loaded_d;

  logic accept;
  logic in_frame;

  assign accept   = bus.rx_valid & rx_ready_q;
  assign in_frame = (state_q == ST_LEN) || (state_q == ST_LO) ||
                    (state_q == ST_HI)  || (state_q == ST_CSUM);

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= ST_HALT;
      n_q        <= '0;
      idx_q      <= '0;
      csum_q     <= '0;
      lo_q       <= '0;
      tmr_q      <= TW'(TIMEOUT);
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      core_q     <= 1'b0;
      err_q      <= 1'b0;
      loaded_q   <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      lo_q       <= lo_d;
      tmr_q      <= tmr_d;
      rx_ready_q <= rx_ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      core_q     <= core_d;
      err_q      <= err_d;
      loaded_q   <= loaded_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    idx_d    = idx_q;
    csum_d   = csum_q;
    lo_d     = lo_q;
    tmr_d    = tmr_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    core_d   = core_q;
    err_d    = err_q;
    loaded_d = loaded_q;

    case (state_q)
      ST_HALT: begin
        if (accept) begin
          if (bus.rx_data == CMD_LOAD) begin
            state_d = ST_LEN;
          end else if (bus.rx_data == CMD_RUN && !err_q && loaded_q != 9'd0) begin
            state_d = ST_RUN;
            core_d  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (bus.rx_data == CMD_HALT) begin
            state_d = ST_HALT;
            core_d  = 1'b0;
          end else if (bus.rx_data == CMD_LOAD) begin
            state_d = ST_LEN;
            core_d  = 1'b0;
          end
        end
      end
      ST_LEN: begin
        if (accept) begin
          n_d     = (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
          idx_d   = '0;
          csum_d  = '0;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (accept) begin
          lo_d    = bus.rx_data;
          csum_d  = csum_q + bus.rx_data;
          state_d = ST_HI;
        end
      end
      ST_HI: begin
        if (accept) begin
          csum_d  = csum_q + bus.rx_data;
          we_d    = 1'b1;
          addr_d  = idx_q[IMEM_AW-1:0];
          wdata_d = {bus.rx_data[6:0], lo_q};
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        idx_d   = idx_q + 9'd1;
        state_d = (idx_q + 9'd1 < n_q) ? ST_LO : ST_CSUM;
      end
      ST_CSUM: begin
        if (accept) begin
          if (bus.rx_data == csum_q) begin
            err_d    = 1'b0;
            loaded_d = n_q;
          end else begin
            err_d = 1'b1;
          end
          state_d = ST_HALT;
        end
      end
      default: state_d = ST_HALT;
    endcase

    // Idle down-counter: reloaded on every accepted byte, frozen outside frames and in WRITE.
    if (accept) begin
      tmr_d = TW'(TIMEOUT);
    end else if (in_frame) begin
      if (tmr_q <= TW'(1)) begin
        state_d = ST_HALT;
        err_d   = 1'b1;
        tmr_d   = TW'(TIMEOUT);
      end else begin
        tmr_d = tmr_q - TW'(1);
      end
    end
  end

  assign rx_ready_d = (state_d != ST_WRITE);

  assign bus.rx_ready   = rx_ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign core_nreset    = core_q;
  assign err            = err_q;
  assign loaded_words   = loaded_q;

endmodule

// File: tb/tb_minc_boot_ctrl.sv
// Self-checking bench for minc_boot_ctrl: directed frames, command table, timeout,
// mid-load reset and randomized traffic against a frame-level model.
module tb_minc_boot_ctrl;
  import minc_pkg::*;

  logic       CLK = 1'b0;
  logic       nRESET = 1'b0;
  logic       core_nreset;
  logic       err;
  logic [8:0] loaded_words;

  minc_boot_if bus();

  minc_boot_ctrl #(.TIMEOUT(16)) dut (
    .CLK          (CLK),
    .nRESET       (nRESET),
    .bus          (bus),
    .core_nreset  (core_nreset),
    .err          (err),
    .loaded_words (loaded_words)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  logic [22:0] obs_q[$];
  bit          m_err;
  int          m_loaded;
  bit          m_run;

  typedef struct {
    logic [7:0] b;
    bit         exp_run;
  } cmd_vec_t;

  cmd_vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (nRESET && bus.imem_we) begin
      obs_q.push_back({bus.imem_addr, bus.imem_wdata});
      chk("ready_low_in_write", {31'd0, bus.rx_ready}, 32'd0);
    end
  end

  // Entry and exit point: 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit done = 0;
    bus.rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge CLK);
      #1;
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge CLK);
      if (bus.rx_ready) done = 1;
      @(posedge CLK);
      #1;
    end
    bus.rx_valid = 1'b0;
    chk("byte_accepted", {31'd0, done}, 32'd1);
  endtask

  task automatic model_cmd(input logic [7:0] b);
    if (b == 8'h5A && !m_err && m_loaded != 0) m_run = 1;
    else if (b == 8'hC3) m_run = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_core_nreset"}, {31'd0, core_nreset}, {31'd0, m_run});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, m_err});
    chk({tag, "_loaded"}, {23'd0, loaded_words}, m_loaded);
  endtask

  task automatic do_frame(input logic [7:0] d[$], input logic [7:0] mask, input int gmax);
    int          n = d.size() / 2;
    logic [7:0]  sum = 8'd0;
    logic [22:0] exp_q[$];
    for (int i = 0; i < d.size(); i++) sum = sum + d[i];
    for (int w = 0; w < n; w++) exp_q.push_back({8'(w), d[2*w+1][6:0], d[2*w]});
    obs_q.delete();
    send_byte(8'hA5, $urandom_range(0, gmax));
    m_run = 0;
    chk("core_reset_on_load", {31'd0, core_nreset}, 32'd0);
    send_byte(8'(n), $urandom_range(0, gmax));
    for (int i = 0; i < d.size(); i++) send_byte(d[i], $urandom_range(0, gmax));
    send_byte(sum ^ mask, $urandom_range(0, gmax));
    chk("write_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk("write_addr_data", {9'd0, obs_q[i]}, {9'd0, exp_q[i]});
    if (mask == 8'd0) begin
      m_err    = 0;
      m_loaded = n;
    end else begin
      m_err = 1;
    end
    check_state("frame");
  endtask

  initial begin
    logic [7:0] d[$];
    logic [7:0] b;
    int         n;

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    #22;
    chk("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    chk("rst_imem_we", {31'd0, bus.imem_we}, 32'd0);
    chk("rst_imem_addr", {24'd0, bus.imem_addr}, 32'd0);
    chk("rst_imem_wdata", {17'd0, bus.imem_wdata}, 32'd0);
    chk("rst_core_nreset", {31'd0, core_nreset}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_loaded", {23'd0, loaded_words}, 32'd0);
    @(negedge CLK);
    nRESET = 1'b1;
    #1;
    chk("ready_before_edge", {31'd0, bus.rx_ready}, 32'd0);
    @(posedge CLK);
    #1;
    chk("ready_after_edge", {31'd0, bus.rx_ready}, 32'd1);
    m_err = 0; m_loaded = 0; m_run = 0;

    send_byte(8'h5A, 0);
    chk("run_refused_unloaded", {31'd0, core_nreset}, 32'd0);

    d = '{8'h34, 8'h12, 8'hFF, 8'h00};
    do_frame(d, 8'h00, 0);
    chk("f1_loaded", {23'd0, loaded_words}, 32'd2);
    chk("f1_err", {31'd0, err}, 32'd0);

    tbl[0] = '{8'h5A, 1'b1};
    tbl[1] = '{8'h77, 1'b1};
    tbl[2] = '{8'hC3, 1'b0};
    tbl[3] = '{8'h77, 1'b0};
    tbl[4] = '{8'hC3, 1'b0};
    tbl[5] = '{8'h5A, 1'b1};
    tbl[6] = '{8'h5A, 1'b1};
    tbl[7] = '{8'hC3, 1'b0};
    for (int i = 0; i < 8; i++) begin
      send_byte(tbl[i].b, i % 3);
      chk("tbl_core_nreset", {31'd0, core_nreset}, {31'd0, tbl[i].exp_run});
      chk("tbl_loaded", {23'd0, loaded_words}, 32'd2);
      model_cmd(tbl[i].b);
    end

    do_frame(d, 8'h01, 1);
    chk("bad_err", {31'd0, err}, 32'd1);
    chk("bad_loaded_kept", {23'd0, loaded_words}, 32'd2);
    send_byte(8'h5A, 0);
    chk("run_refused_err", {31'd0, core_nreset}, 32'd0);

    d.delete();
    for (int i = 0; i < 512; i++) d.push_back(8'h01);
    do_frame(d, 8'h00, 0);
    chk("n256_loaded", {23'd0, loaded_words}, 32'd256);

    obs_q.delete();
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h10, 0);
    repeat (15) begin
      @(posedge CLK);
      #1;
    end
    chk("timeout_not_yet", {31'd0, err}, 32'd0);
    @(posedge CLK);
    #1;
    chk("timeout_err", {31'd0, err}, 32'd1);
    m_err = 1; m_run = 0;
    check_state("timeout");
    chk("timeout_no_write", obs_q.size(), 0);
    send_byte(8'h5A, 0);
    chk("run_refused_timeout", {31'd0, core_nreset}, 32'd0);
    d = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    do_frame(d, 8'h00, 2);
    chk("recover_err", {31'd0, err}, 32'd0);

    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    nRESET = 1'b0;
    #2;
    chk("midrst_loaded", {23'd0, loaded_words}, 32'd0);
    chk("midrst_ready", {31'd0, bus.rx_ready}, 32'd0);
    chk("midrst_core", {31'd0, core_nreset}, 32'd0);
    m_err = 0; m_loaded = 0; m_run = 0;
    @(negedge CLK);
    nRESET = 1'b1;
    @(posedge CLK);
    #1;
    send_byte(8'h5A, 0);
    check_state("after_midrst");

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          n = $urandom_range(1, 8);
          d.delete();
          for (int i = 0; i < 2 * n; i++) d.push_back(8'($urandom));
          do_frame(d, ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, 3);
        end
        2: begin
          send_byte(8'h5A, $urandom_range(0, 3));
          model_cmd(8'h5A);
          check_state("rnd_run");
        end
        default: begin
          b = ($urandom_range(0, 1) == 0) ? 8'hC3 : 8'($urandom);
          if (b == 8'hA5) b = 8'h00;
          send_byte(b, $urandom_range(0, 3));
          model_cmd(b);
          check_state("rnd_cmd");
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
